// File: rtl/shunt_fringe_pkg.sv
// Shared Fringe framework types and defaults used by the put-side payload serializer.
// Struct widths follow the package defaults.
package shunt_fringe_pkg;

   localparam int FRNG_N_OF_SIGNALS             = 8;
   localparam int FRNG_MAX_N_OF_BITS_PER_SIGNAL = 1024;
   localparam int FRNG_N_OF_BITS_PER_PAYLOAD    = 64;
   localparam int FRNG_SIG_IDX_W                = $clog2(FRNG_N_OF_SIGNALS);
   localparam int FRNG_PL_IDX_W                 = $clog2(FRNG_MAX_N_OF_BITS_PER_SIGNAL / FRNG_N_OF_BITS_PER_PAYLOAD);

   typedef enum logic [1:0] {
      FRNG_SER_IDLE,
      FRNG_SER_SEND,
      FRNG_SER_STATUS
   } fringe_ser_state_e;

   typedef struct packed {
      logic [FRNG_N_OF_BITS_PER_PAYLOAD-1:0] data_bit;
      logic [FRNG_N_OF_BITS_PER_PAYLOAD-1:0] data_logic;
   } signal_db_data_in_t;

   typedef struct packed {
      logic [FRNG_SIG_IDX_W-1:0] signal_index;
      logic [FRNG_PL_IDX_W-1:0]  payload_index;
      logic                      last;
      signal_db_data_in_t        data;
   } fringe_payload_slice_t;

   typedef struct packed {
      logic                      valid;
      logic                      success;
      logic [FRNG_SIG_IDX_W-1:0] signal_index;
      logic [63:0]               event_cnt;
   } put_get_status_t;

   function automatic int unsigned frng_ceil_div(input int unsigned num, input int unsigned den);
      return (num + den - 1) / den;
   endfunction

endpackage

// File: rtl/fringe_event_counter_bank.sv
// Per-signal 64-bit event counters: one increment port, one combinational read port.
// All counters clear on reset.
module fringe_event_counter_bank #(
   parameter int N_OF_SIGNALS = 8,
   parameter int CNT_W        = 64
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            inc_valid,
   input  logic [$clog2(N_OF_SIGNALS)-1:0] inc_index,
   input  logic [$clog2(N_OF_SIGNALS)-1:0] rd_index,
   output logic [CNT_W-1:0]                rd_cnt
);
   localparam int IDX_W = $clog2(N_OF_SIGNALS);

   logic [CNT_W-1:0] cnt [N_OF_SIGNALS];

   generate
      for (genvar gi = 0; gi < N_OF_SIGNALS; gi++) begin : g_cnt
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt[gi] <= '0;
            end else if (inc_valid && inc_index == IDX_W'(gi)) begin
               cnt[gi] <= cnt[gi] + CNT_W'(1);
            end
         end
      end
   endgenerate

   assign rd_cnt = cnt[rd_index];

endmodule

// File: rtl/fringe_payload_serializer.sv
// Splits one captured signal update into fixed-width payloads on a valid/ready stream,
// then pulses a per-signal status carrying the updated event count.
module fringe_payload_serializer
   import shunt_fringe_pkg::*;
#(
   parameter int N_OF_SIGNALS = FRNG_N_OF_SIGNALS,
   parameter int MAX_BITS     = FRNG_MAX_N_OF_BITS_PER_SIGNAL,
   parameter int PL_BITS      = FRNG_N_OF_BITS_PER_PAYLOAD,
   parameter int MAX_PL       = MAX_BITS / PL_BITS
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            put_valid,
   output logic                            put_ready,
   input  logic [$clog2(N_OF_SIGNALS)-1:0] put_signal_index,
   input  logic [$clog2(MAX_BITS):0]       put_signal_size,
   input  logic [MAX_BITS-1:0]             put_data_bit,
   input  logic [MAX_BITS-1:0]             put_data_logic,
   output logic                            pl_valid,
   input  logic                            pl_ready,
   output logic [$clog2(N_OF_SIGNALS)-1:0] pl_signal_index,
   output logic [$clog2(MAX_PL)-1:0]       pl_payload_index,
   output logic                            pl_last,
   output logic [PL_BITS-1:0]              pl_data_bit,
   output logic [PL_BITS-1:0]              pl_data_logic,
   output logic                            status_valid,
   output logic                            status_success,
   output logic [$clog2(N_OF_SIGNALS)-1:0] status_signal_index,
   output logic [63:0]                     status_event_cnt
);
   localparam int SIG_W  = $clog2(N_OF_SIGNALS);
   localparam int SIZE_W = $clog2(MAX_BITS) + 1;
   localparam int PLI_W  = $clog2(MAX_PL);
   localparam int NPL_W  = PLI_W + 1;
   localparam int PL_SH  = $clog2(PL_BITS);

   fringe_ser_state_e      state;
   logic [SIG_W-1:0]       index_reg;
   logic [MAX_BITS-1:0]    data_bit_reg;
   logic [MAX_BITS-1:0]    data_logic_reg;
   logic [NPL_W-1:0]       n_pl_reg;
   logic [PLI_W-1:0]       pl_cnt;
   logic                   success_reg;
   logic [MAX_BITS-1:0]    keep_mask;
   logic                   size_legal;
   logic                   last_pl;
   logic                   inc_valid;
   logic [SIZE_W-2:0]      pl_base;
   logic [63:0]            cnt_rd;
   fringe_payload_slice_t  slice;
   put_get_status_t        status;

   // Bits beyond the signal size are zeroed at capture so the tail of the last payload is clean.
   generate
      for (genvar gi = 0; gi < MAX_BITS; gi++) begin : g_mask
         assign keep_mask[gi] = (SIZE_W'(gi) < put_signal_size);
      end
   endgenerate

   assign size_legal = (put_signal_size != '0) && (put_signal_size <= SIZE_W'(MAX_BITS));
   assign last_pl    = (state == FRNG_SER_SEND) && ({1'b0, pl_cnt} == n_pl_reg - NPL_W'(1));
   assign inc_valid  = (state == FRNG_SER_SEND) && pl_ready && last_pl;
   assign pl_base    = {pl_cnt, {PL_SH{1'b0}}};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= FRNG_SER_IDLE;
         index_reg      <= '0;
         data_bit_reg   <= '0;
         data_logic_reg <= '0;
         n_pl_reg       <= '0;
         pl_cnt         <= '0;
         success_reg    <= 1'b0;
      end else begin
         case (state)
            FRNG_SER_IDLE: begin
               if (put_valid) begin
                  index_reg      <= put_signal_index;
                  data_bit_reg   <= put_data_bit & keep_mask;
                  data_logic_reg <= put_data_logic & keep_mask;
                  n_pl_reg       <= NPL_W'(frng_ceil_div(32'(put_signal_size), PL_BITS));
                  pl_cnt         <= '0;
                  success_reg    <= size_legal;
                  state          <= size_legal ? FRNG_SER_SEND : FRNG_SER_STATUS;
               end
            end
            FRNG_SER_SEND: begin
               if (pl_ready) begin
                  if (last_pl) state <= FRNG_SER_STATUS;
                  else         pl_cnt <= pl_cnt + PLI_W'(1);
               end
            end
            FRNG_SER_STATUS: state <= FRNG_SER_IDLE;
            default:         state <= FRNG_SER_IDLE;
         endcase
      end
   end

   always_comb begin
      slice = '0;
      if (state == FRNG_SER_SEND) begin
         slice.signal_index    = index_reg;
         slice.payload_index   = pl_cnt;
         slice.last            = last_pl;
         slice.data.data_bit   = data_bit_reg[pl_base +: PL_BITS];
         slice.data.data_logic = data_logic_reg[pl_base +: PL_BITS];
      end
   end

   // The counter was bumped on the last handshake, so the read port already shows the new value.
   always_comb begin
      status = '0;
      if (state == FRNG_SER_STATUS) begin
         status.valid        = 1'b1;
         status.success      = success_reg;
         status.signal_index = index_reg;
         status.event_cnt    = cnt_rd;
      end
   end

   fringe_event_counter_bank #(
      .N_OF_SIGNALS (N_OF_SIGNALS),
      .CNT_W        (64)
   ) u_cnt_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc_valid (inc_valid),
      .inc_index (index_reg),
      .rd_index  (index_reg),
      .rd_cnt    (cnt_rd)
   );

   assign put_ready           = (state == FRNG_SER_IDLE);
   assign pl_valid            = (state == FRNG_SER_SEND);
   assign pl_signal_index     = slice.signal_index;
   assign pl_payload_index    = slice.payload_index;
   assign pl_last             = slice.last;
   assign pl_data_bit         = slice.data.data_bit;
   assign pl_data_logic       = slice.data.data_logic;
   assign status_valid        = status.valid;
   assign status_success      = status.success;
   assign status_signal_index = status.signal_index;
   assign status_event_cnt    = status.event_cnt;

endmodule

// File: tb/tb_fringe_payload_serializer.sv
// Table-driven bench with payload/status scoreboards and hand-written reset-abort sequence.
module tb_fringe_payload_serializer;

   logic          clk;
   logic          rst_n;
   logic          put_valid;
   logic          put_ready;
   logic [2:0]    put_signal_index;
   logic [10:0]   put_signal_size;
   logic [1023:0] put_data_bit;
   logic [1023:0] put_data_logic;
   logic          pl_valid;
   logic          pl_ready;
   logic [2:0]    pl_signal_index;
   logic [3:0]    pl_payload_index;
   logic          pl_last;
   logic [63:0]   pl_data_bit;
   logic [63:0]   pl_data_logic;
   logic          status_valid;
   logic          status_success;
   logic [2:0]    status_signal_index;
   logic [63:0]   status_event_cnt;

   fringe_payload_serializer dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .put_valid           (put_valid),
      .put_ready           (put_ready),
      .put_signal_index    (put_signal_index),
      .put_signal_size     (put_signal_size),
      .put_data_bit        (put_data_bit),
      .put_data_logic      (put_data_logic),
      .pl_valid            (pl_valid),
      .pl_ready            (pl_ready),
      .pl_signal_index     (pl_signal_index),
      .pl_payload_index    (pl_payload_index),
      .pl_last             (pl_last),
      .pl_data_bit         (pl_data_bit),
      .pl_data_logic       (pl_data_logic),
      .status_valid        (status_valid),
      .status_success      (status_success),
      .status_signal_index (status_signal_index),
      .status_event_cnt    (status_event_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      logic [2:0]  idx;
      logic [3:0]  pidx;
      logic        last;
      logic [63:0] db;
      logic [63:0] dl;
   } pl_exp_t;

   typedef struct {
      logic        succ;
      logic [2:0]  idx;
      logic [63:0] cnt;
   } st_exp_t;

   pl_exp_t plq[$];
   st_exp_t stq[$];

   // Monitor-owned observation state
   int          pl_total = 0;
   int          status_total = 0;
   int          first_valid_cyc = 0;
   int          last_hs_cyc = 0;
   int          status_cyc = 0;
   logic [63:0] last_pl_bit = '0;
   bit          prev_valid = 0;
   bit          stalled = 0;
   logic [3:0]  held_pidx = '0;
   logic [63:0] held_db = '0;
   logic [63:0] held_dl = '0;

   always begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
         prev_valid = 0;
         stalled    = 0;
      end else begin
         if (pl_valid && !prev_valid) first_valid_cyc = cyc;
         if (pl_valid) chk("put_ready_in_send", put_ready, 0);
         if (stalled) begin
            chk("stall_valid", pl_valid, 1);
            chk("stall_pidx", pl_payload_index, held_pidx);
            chk("stall_data_bit", pl_data_bit, held_db);
            chk("stall_data_logic", pl_data_logic, held_dl);
         end
         if (pl_valid && pl_ready) begin
            if (plq.size() == 0) begin
               chk("spurious_payload", pl_valid, 0);
            end else begin
               pl_exp_t e;
               e = plq.pop_front();
               chk("pl_signal_index", pl_signal_index, e.idx);
               chk("pl_payload_index", pl_payload_index, e.pidx);
               chk("pl_last", pl_last, e.last);
               chk("pl_data_bit", pl_data_bit, e.db);
               chk("pl_data_logic", pl_data_logic, e.dl);
            end
            pl_total++;
            if (pl_last) begin
               last_hs_cyc = cyc;
               last_pl_bit = pl_data_bit;
            end
         end
         stalled   = pl_valid && !pl_ready;
         held_pidx = pl_payload_index;
         held_db   = pl_data_bit;
         held_dl   = pl_data_logic;
         if (status_valid) begin
            if (stq.size() == 0) begin
               chk("spurious_status", status_valid, 0);
            end else begin
               st_exp_t s;
               s = stq.pop_front();
               chk("status_success", status_success, s.succ);
               chk("status_signal_index", status_signal_index, s.idx);
               chk("status_event_cnt", status_event_cnt, s.cnt);
            end
            chk("put_ready_in_status", put_ready, 0);
            status_cyc = cyc;
            status_total++;
         end
         prev_valid = pl_valid;
      end
   end

   typedef struct {
      int          idx;
      int          size;
      int          pat;
      int          rmode;
      int          hold;
      int          npl;
      int          succ;
      logic [63:0] cnt;
   } vec_t;

   vec_t tbl[9];

   task automatic build_data(input int pat, output logic [1023:0] db, output logic [1023:0] dl);
      for (int i = 0; i < 128; i++) begin
         logic [31:0] b32;
         b32 = i;
         db[i*8 +: 8] = b32[7:0];
      end
      dl = ~db;
      if (pat != 0) begin
         for (int i = 0; i < 32; i++) begin
            db[i*32 +: 32] = $urandom;
            dl[i*32 +: 32] = $urandom;
         end
      end
   endtask

   task automatic push_expect(input int idx, input int size, input int npl, input int succ,
                              input logic [63:0] cnt, input logic [1023:0] db, input logic [1023:0] dl);
      logic [31:0] idx32;
      idx32 = idx;
      for (int k = 0; k < npl; k++) begin
         pl_exp_t e;
         logic [31:0] k32;
         k32 = k;
         e.idx  = idx32[2:0];
         e.pidx = k32[3:0];
         e.last = (k == npl - 1);
         for (int b = 0; b < 64; b++) begin
            int pos;
            pos = k * 64 + b;
            e.db[b] = (pos < size) ? db[pos] : 1'b0;
            e.dl[b] = (pos < size) ? dl[pos] : 1'b0;
         end
         plq.push_back(e);
      end
      begin
         st_exp_t s;
         s.succ = (succ != 0);
         s.idx  = idx32[2:0];
         s.cnt  = cnt;
         stq.push_back(s);
      end
   endtask

   task automatic drive_put(input int idx, input int size, input logic [1023:0] db, input logic [1023:0] dl);
      logic [31:0] idx32;
      logic [31:0] size32;
      idx32  = idx;
      size32 = size;
      chk("put_ready_idle", put_ready, 1);
      put_valid        = 1'b1;
      put_signal_index = idx32[2:0];
      put_signal_size  = size32[10:0];
      put_data_bit     = db;
      put_data_logic   = dl;
      pl_ready         = 1'b1;
   endtask

   task automatic do_put(input vec_t v);
      logic [1023:0] db;
      logic [1023:0] dl;
      int c, j, pl_before, st_before;
      build_data(v.pat, db, dl);
      push_expect(v.idx, v.size, v.npl, v.succ, v.cnt, db, dl);
      pl_before = pl_total;
      st_before = status_total;
      @(negedge clk);
      drive_put(v.idx, v.size, db, dl);
      c = cyc;
      j = 0;
      while (status_total == st_before && j < 200) begin
         @(negedge clk);
         j++;
         if (status_total == st_before) begin
            put_valid = (v.hold != 0);
            pl_ready  = (v.rmode == 1) ? ((j % 2) == 1) : 1'b1;
         end
      end
      put_valid = 1'b0;
      pl_ready  = 1'b1;
      chk("status_seen", 64'(status_total - st_before), 1);
      chk("put_ready_back", put_ready, 1);
      chk("put_ready_latency", 64'(cyc - status_cyc), 1);
      chk("n_payloads", 64'(pl_total - pl_before), 64'(v.npl));
      if (v.npl > 0) begin
         chk("first_valid_latency", 64'(first_valid_cyc - c), 1);
         chk("status_latency", 64'(status_cyc - last_hs_cyc), 1);
         chk("send_span", 64'(last_hs_cyc - first_valid_cyc + 1),
             64'((v.rmode == 1) ? 2 * v.npl - 1 : v.npl));
      end else begin
         chk("illegal_status_latency", 64'(status_cyc - c), 1);
      end
      $display("put idx=%0d size=%0d payloads=%0d status_cnt=%0d", v.idx, v.size,
               pl_total - pl_before, status_event_cnt);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{idx:3, size:200,  pat:0, rmode:0, hold:1, npl:4,  succ:1, cnt:64'd1};
      tbl[1] = '{idx:0, size:64,   pat:1, rmode:0, hold:0, npl:1,  succ:1, cnt:64'd1};
      tbl[2] = '{idx:0, size:64,   pat:1, rmode:0, hold:0, npl:1,  succ:1, cnt:64'd2};
      tbl[3] = '{idx:0, size:64,   pat:1, rmode:0, hold:0, npl:1,  succ:1, cnt:64'd3};
      tbl[4] = '{idx:3, size:0,    pat:1, rmode:0, hold:0, npl:0,  succ:0, cnt:64'd1};
      tbl[5] = '{idx:5, size:1025, pat:1, rmode:0, hold:1, npl:0,  succ:0, cnt:64'd0};
      tbl[6] = '{idx:2, size:1,    pat:1, rmode:0, hold:0, npl:1,  succ:1, cnt:64'd1};
      tbl[7] = '{idx:3, size:65,   pat:1, rmode:1, hold:0, npl:2,  succ:1, cnt:64'd2};
      tbl[8] = '{idx:1, size:1024, pat:0, rmode:1, hold:0, npl:16, succ:1, cnt:64'd1};

      rst_n            = 1'b0;
      put_valid        = 1'b0;
      put_signal_index = '0;
      put_signal_size  = '0;
      put_data_bit     = '0;
      put_data_logic   = '0;
      pl_ready         = 1'b1;
      #3;
      chk("rst_put_ready", put_ready, 1);
      chk("rst_pl_valid", pl_valid, 0);
      chk("rst_pl_last", pl_last, 0);
      chk("rst_pl_data_bit", pl_data_bit, 0);
      chk("rst_status_valid", status_valid, 0);
      chk("rst_status_event_cnt", status_event_cnt, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         do_put(tbl[i]);
         if (i == 0) chk("size200_pl3_bits", last_pl_bit, 64'h18);
      end

      // Reset in the middle of a 1024-bit put on a signal whose counter is 3
      begin
         logic [1023:0] db;
         logic [1023:0] dl;
         int j;
         build_data(1, db, dl);
         push_expect(0, 1024, 16, 1, 64'd4, db, dl);
         @(negedge clk);
         drive_put(0, 1024, db, dl);
         j = 0;
         do begin
            @(negedge clk);
            put_valid = 1'b0;
            j++;
         end while (!(pl_valid && pl_payload_index == 4'd5) && j < 50);
         chk("abort_reached_pl5", pl_payload_index, 5);
         #1;
         rst_n = 1'b0;
         #1;
         chk("abort_pl_valid", pl_valid, 0);
         chk("abort_put_ready", put_ready, 1);
         chk("abort_pl_index", pl_payload_index, 0);
         chk("abort_pl_data_bit", pl_data_bit, 0);
         chk("abort_status_valid", status_valid, 0);
         plq.delete();
         stq.delete();
         repeat (2) @(negedge clk);
         rst_n = 1'b1;
         repeat (3) begin
            @(negedge clk);
            chk("abort_no_status", status_valid, 0);
         end
         $display("put idx=0 size=1024 aborted by reset");
      end
      do_put('{idx:0, size:64, pat:1, rmode:0, hold:0, npl:1, succ:1, cnt:64'd1});

      repeat (2) @(negedge clk);
      chk("queues_drained", 64'(plq.size() + stq.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
